// File: rtl/fallthrough_fifo_small_if.sv
// Handshake bundle for fallthrough_fifo_small: write side, pop strobe, head word and flags.
// The master modport is the user (producer/consumer); the slave modport is the FIFO itself.
interface fallthrough_fifo_small_if #(
    parameter int WIDTH = 72
) ();
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             nearly_full;
    logic             empty;

    modport master (
        output din,
        output wr_en,
        output rd_en,
        input  dout,
        input  full,
        input  nearly_full,
        input  empty
    );

    modport slave (
        input  din,
        input  wr_en,
        input  rd_en,
        output dout,
        output full,
        output nearly_full,
        output empty
    );
endinterface

// File: rtl/fallthrough_fifo_small.sv
// Small first-word-fall-through FIFO: head word is shown on dout whenever non-empty.
// Define FALLTHROUGH_FIFO_ERR_MSG_EN to get simulation-only overflow/underflow messages.
module fallthrough_fifo_small #(
    parameter int WIDTH             = 72,
    parameter int MAX_DEPTH_BITS    = 3,
    parameter int NEARLY_FULL_SLACK = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    fallthrough_fifo_small_if.slave       bus
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_LEVEL = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NF_LEVEL    = (MAX_DEPTH_BITS + 1)'(DEPTH - NEARLY_FULL_SLACK);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAX_DEPTH_BITS:0]   count_q, count_d;
    logic                      full_w, empty_w;
    logic                      wr_accept, rd_accept;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_LEVEL);

    // A write into a full FIFO is still accepted when the same edge pops the head.
    assign rd_accept = bus.rd_en && !empty_w;
    assign wr_accept = bus.wr_en && (!full_w || rd_accept);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the reset cycle merely suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && wr_accept) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.dout        = mem_q[rd_ptr_q];
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.nearly_full = (count_q >= NF_LEVEL);

`ifdef FALLTHROUGH_FIFO_ERR_MSG_EN
    always @(posedge clk) begin
        if (reset) begin
            if (bus.wr_en && full_w && !bus.rd_en) begin
                $display("%m: overflow, write while full dropped at time %0t", $time);
            end
            if (bus.rd_en && empty_w) begin
                $display("%m: underflow, read while empty ignored at time %0t", $time);
            end
        end
    end
`else
`endif
endmodule

// File: tb/tb_fallthrough_fifo_small.sv
// Self-checking bench for fallthrough_fifo_small: directed steps plus random traffic,
// compared every cycle against a queue-based model of the FIFO.
module tb_fallthrough_fifo_small;
    localparam int W     = 72;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] model_q [$];

    fallthrough_fifo_small_if #(.WIDTH(W)) bus ();

    fallthrough_fifo_small #(
        .WIDTH(W),
        .MAX_DEPTH_BITS(3),
        .NEARLY_FULL_SLACK(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all flags, and the head word when the model holds data.
    task automatic check_state(input string tag);
        chk({tag, "_empty"}, W'(bus.empty), W'(model_q.size() == 0));
        chk({tag, "_full"}, W'(bus.full), W'(model_q.size() == DEPTH));
        chk({tag, "_nfull"}, W'(bus.nearly_full), W'(model_q.size() >= DEPTH - 1));
        if (model_q.size() > 0) begin
            chk({tag, "_dout"}, bus.dout, model_q[0]);
        end
    endtask

    // One clock with the given strobes; model applies FIFO rules from pre-edge occupancy.
    task automatic cycle(input logic w, input logic r, input logic [W-1:0] d, input string tag);
        bit rd_ok, wr_ok;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
        rd_ok = r && (model_q.size() > 0);
        wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
        @(posedge clk);
        #1;
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        $display("cycle %-10s wr=%0b rd=%0b din=%h occ=%0d", tag, w, r, d, model_q.size());
        check_state(tag);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.wr_en = 1'($urandom);
            bus.rd_en = 1'($urandom);
            bus.din   = {8'($urandom), $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        model_q.delete();
        reset = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        $display("reset held %0d cycles", n);
        check_state("reset");
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    initial begin
        int sent;
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        #1;

        // Reset then idle
        do_reset(2);
        chk("rst_empty_const", W'(bus.empty), W'(1));
        cycle(1'b0, 1'b0, '0, "idle");
        cycle(1'b0, 1'b0, '0, "idle");

        // Single fall-through without priming read
        cycle(1'b1, 1'b0, 72'h0FF_0000_0000_0000_0001, "ft_wr");
        chk("ft_dout_const", bus.dout, 72'h0FF_0000_0000_0000_0001);
        cycle(1'b0, 1'b1, '0, "ft_rd");
        chk("ft_empty_const", W'(bus.empty), W'(1));

        // Fill, overflow attempt, drain
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, W'(i), "fill");
            if (i == 7) chk("nfull_at7", W'(bus.nearly_full), W'(1));
        end
        chk("full_at8", W'(bus.full), W'(1));
        cycle(1'b1, 1'b0, W'(9), "overflow");
        chk("ovf_head", bus.dout, W'(1));
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", bus.dout, W'(i));
            cycle(1'b0, 1'b1, '0, "drain");
        end
        chk("drained_empty", W'(bus.empty), W'(1));
        cycle(1'b0, 1'b1, '0, "underflow");

        // Simultaneous read+write when empty, then at full
        cycle(1'b1, 1'b1, W'(16'h0E0E), "rw_empty");
        chk("rw_empty_head", bus.dout, W'(16'h0E0E));
        cycle(1'b0, 1'b1, '0, "pop");
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'(32'h100 + i), "fill2");
        cycle(1'b1, 1'b1, W'(32'hAAAA), "rw_full");
        chk("rw_full_flag", W'(bus.full), W'(1));
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, "drain2");

        // Wrap-around stream of 20 words with random bursts
        sent = 0;
        for (int c = 0; c < 400 && (sent < 20 || model_q.size() > 0); c++) begin
            logic w, r;
            w = (sent < 20) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (w && (model_q.size() < DEPTH || (r && model_q.size() > 0))) sent++;
            cycle(w, r, rnd_word(), "stream");
        end
        chk("stream_done", W'(bus.empty), W'(1));

        // Fully random traffic
        for (int c = 0; c < 300; c++) begin
            cycle(1'($urandom), 1'($urandom), rnd_word(), "random");
        end
        for (int c = 0; c < DEPTH; c++) cycle(1'b0, 1'b1, '0, "flush");

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, rnd_word(), "pre_rst");
        do_reset(1);
        chk("midrst_empty", W'(bus.empty), W'(1));
        cycle(1'b1, 1'b0, W'(8'h55), "post_rst");
        chk("post_rst_dout", bus.dout, W'(8'h55));
        cycle(1'b0, 1'b1, '0, "post_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
